// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - CPU-side and memory-side signal bundle for the data cache controller
interface dcache_ctrl_if;
    logic        cpu_MemRead_i;
    logic        cpu_MemWrite_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        cpu_stall_o;
    logic        mem_MemRead_o;
    logic        mem_MemWrite_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;

    // master drives CPU requests and returns memory read data; slave is the cache
    modport master (
        output cpu_MemRead_i, cpu_MemWrite_i, cpu_addr_i, cpu_data_i, mem_data_i,
        input  cpu_data_o, cpu_stall_o, mem_MemRead_o, mem_MemWrite_o, mem_addr_o, mem_data_o
    );
    modport slave (
        input  cpu_MemRead_i, cpu_MemWrite_i, cpu_addr_i, cpu_data_i, mem_data_i,
        output cpu_data_o, cpu_stall_o, mem_MemRead_o, mem_MemWrite_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache, one word per line
module dcache_ctrl #(
    parameter int NUM_LINES = 16,
    parameter int MEM_LAT   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    dcache_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 30 - IDX_W;
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, WBACK, FILL} state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [31:0]          data_mem [NUM_LINES];
    logic                 mem_rd_q;
    logic                 mem_wr_q;
    logic [31:0]          mem_addr_q;
    logic [31:0]          mem_wdata_q;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] req_tag;
    logic             is_wr;
    logic             is_rd;
    logic             req;
    logic             hit;
    logic             cnt_done;
    logic             unused_addr_lsb;

    assign idx             = bus.cpu_addr_i[IDX_W+1:2];
    assign req_tag         = bus.cpu_addr_i[31:IDX_W+2];
    assign unused_addr_lsb = ^bus.cpu_addr_i[1:0];
    // a simultaneous read and write strobe is handled as a store
    assign is_wr    = bus.cpu_MemWrite_i;
    assign is_rd    = bus.cpu_MemRead_i & ~bus.cpu_MemWrite_i;
    assign req      = is_wr | is_rd;
    assign hit      = valid_q[idx] && (tag_mem[idx] == req_tag);
    assign cnt_done = (cnt_q == CNT_LAST);

    // stall rises in the miss cycle itself so the pipeline never latches stale data
    assign bus.cpu_stall_o    = (state_q != IDLE) || (req && !hit);
    assign bus.cpu_data_o     = (state_q == IDLE && is_rd && hit) ? data_mem[idx] : 32'd0;
    assign bus.mem_MemRead_o  = mem_rd_q;
    assign bus.mem_MemWrite_o = mem_wr_q;
    assign bus.mem_addr_o     = mem_addr_q;
    assign bus.mem_data_o     = mem_wdata_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req && !hit) begin
                        cnt_q <= '0;
                        if (valid_q[idx] && dirty_q[idx]) begin
                            state_q     <= WBACK;
                            mem_wr_q    <= 1'b1;
                            mem_addr_q  <= {tag_mem[idx], idx, 2'b00};
                            mem_wdata_q <= data_mem[idx];
                        end else begin
                            state_q    <= FILL;
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= {bus.cpu_addr_i[31:2], 2'b00};
                        end
                    end else if (is_wr && hit) begin
                        dirty_q[idx] <= 1'b1;
                    end
                end
                WBACK: begin
                    if (cnt_done) begin
                        state_q     <= FILL;
                        cnt_q       <= '0;
                        mem_wr_q    <= 1'b0;
                        mem_wdata_q <= '0;
                        mem_rd_q    <= 1'b1;
                        mem_addr_q  <= {bus.cpu_addr_i[31:2], 2'b00};
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                FILL: begin
                    if (cnt_done) begin
                        state_q      <= IDLE;
                        cnt_q        <= '0;
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                        mem_rd_q     <= 1'b0;
                        mem_addr_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // tag/data arrays carry no reset; valid bits alone decide whether a line is usable
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if (state_q == IDLE && is_wr && hit) begin
                data_mem[idx] <= bus.cpu_data_i;
            end else if (state_q == FILL && cnt_done) begin
                data_mem[idx] <= bus.mem_data_i;
                tag_mem[idx]  <= req_tag;
            end
        end
    end
endmodule
